// File: rtl/ro_meas_pkg.sv
// ro_meas_pkg: shared FSM state encoding and parameter defaults for the ring-oscillator measurement sequencer.
package ro_meas_pkg;
    localparam int CNT_W_DEF      = 24;
    localparam int WIN_W_DEF      = 16;
    localparam int SETTLE_CYC_DEF = 8;
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE   = 2'd0;
    localparam state_t S_SETTLE = 2'd1;
    localparam state_t S_GATE   = 2'd2;
    localparam state_t S_HOLD   = 2'd3;
endpackage

// File: rtl/ro_edge_sync.sv
// ro_edge_sync: 2-FF synchronizer plus edge flop; one-cycle pulse on each synchronized rising edge.
module ro_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise_pulse
);
    // [0] metastable stage, [1] synchronized, [2] previous synchronized value
    logic [2:0] sh_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sh_q <= '0;
        else        sh_q <= {sh_q[1:0], async_in};
    end
    assign rise_pulse = sh_q[1] & ~sh_q[2];
endmodule

// File: rtl/ro_measure_sequencer.sv
// ro_measure_sequencer: settles a selected ring oscillator, counts its edges over a gate window
// and hands the count out, optionally scanning mux channels upward to 15.
module ro_measure_sequencer
    import ro_meas_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int WIN_W      = WIN_W_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_chan,
    input  logic [4:0]       cmd_stages,
    input  logic [WIN_W-1:0] cmd_window,
    input  logic             cmd_scan,
    input  logic             abort,
    input  logic             ro_in,
    output logic [3:0]       mux_sel,
    output logic [4:0]       ro_s,
    output logic             ro_start,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_data,
    output logic [3:0]       res_chan,
    output logic             busy
);
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int TW = (WIN_W > SW) ? WIN_W : SW;

    state_t           state_q, state_d;
    logic [3:0]       chan_q, chan_d;
    logic [4:0]       stg_q, stg_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic             scan_q, scan_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise;

    ro_edge_sync u_sync (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_n),
        .async_in  (ro_in),
        .rise_pulse(rise)
    );

    // cmd_ready is gated by reset so it stays low while the block is held in reset
    assign cmd_ready = wb_rst_n && (state_q == S_IDLE) && !abort;
    assign busy      = state_q != S_IDLE;
    assign ro_start  = (state_q == S_SETTLE) || (state_q == S_GATE);
    assign res_valid = state_q == S_HOLD;
    assign res_data  = cnt_q;
    assign res_chan  = chan_q;
    assign mux_sel   = chan_q;
    assign ro_s      = stg_q;

    logic settle_done, gate_done;
    assign settle_done = tmr_q == TW'(SETTLE_CYC - 1);
    assign gate_done   = tmr_q == TW'(win_q) - TW'(1);

    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        stg_d   = stg_q;
        win_d   = win_q;
        scan_d  = scan_q;
        tmr_d   = tmr_q + TW'(1);
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (cmd_valid && cmd_ready) begin
                chan_d  = cmd_chan;
                stg_d   = cmd_stages;
                win_d   = cmd_window;
                scan_d  = cmd_scan;
                tmr_d   = '0;
                state_d = S_SETTLE;
            end
            S_SETTLE: if (settle_done) begin
                tmr_d   = '0;
                cnt_d   = '0;
                state_d = (win_q == '0) ? S_HOLD : S_GATE;
            end
            S_GATE: begin
                cnt_d   = (rise && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
                state_d = gate_done ? S_HOLD : S_GATE;
            end
            default: if (res_ready && !abort) begin
                chan_d  = (scan_q && chan_q != 4'hf) ? chan_q + 4'd1 : chan_q;
                tmr_d   = '0;
                state_d = (scan_q && chan_q != 4'hf) ? S_SETTLE : S_IDLE;
            end
        endcase
        if (abort) state_d = S_IDLE;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q <= S_IDLE;
            chan_q  <= '0;
            stg_q   <= '0;
            win_q   <= '0;
            scan_q  <= 1'b0;
            tmr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            stg_q   <= stg_d;
            win_q   <= win_d;
            scan_q  <= scan_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
